// File: rtl/axi4_lite_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
// Holds response codes and the byte-strobe merge function.
package axi4_lite_regfile_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic logic [WORD_W-1:0] strb_merge(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing N_REGS 32-bit control/status registers.
// Ports: AW/W/B and AR/R channels, reg_o contents, hw_i RO status, wr_pulse_o.
module axi4_lite_regfile
  import axi4_lite_regfile_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_REGS = 8,
  parameter logic [N_REGS-1:0] RO_MASK = 8'b1100_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output resp_t                    bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output resp_t                    rresp,
  output logic [N_REGS*DATA_W-1:0] reg_o,
  input  logic [N_REGS*DATA_W-1:0] hw_i,
  output logic [N_REGS-1:0]        wr_pulse_o
);

  localparam int IDX_W = $clog2(N_REGS);

  typedef logic [IDX_W-1:0] idx_t;

  logic [N_REGS-1:0][DATA_W-1:0] regs_q;
  logic [N_REGS-1:0][DATA_W-1:0] hw_w;

  logic              aw_held;
  logic              w_held;
  idx_t              aw_idx_q;
  logic              aw_err_q;
  logic [DATA_W-1:0] w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_oor, ar_oor;
  idx_t aw_idx, ar_idx;
  logic unused_ok;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = aw_held && w_held;

  assign aw_idx = awaddr[IDX_W+1:2];
  assign ar_idx = araddr[IDX_W+1:2];
  assign aw_oor = |awaddr[ADDR_W-1:IDX_W+2];
  assign ar_oor = |araddr[ADDR_W-1:IDX_W+2];

  assign hw_w  = hw_i;
  assign reg_o = regs_q;

  assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  // Error status is resolved at AW time so commit needs only the index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q     <= '0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx_q   <= '0;
      aw_err_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx;
        aw_err_q <= aw_oor || RO_MASK[aw_idx];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        if (aw_err_q) begin
          bresp <= RESP_SLVERR;
        end else begin
          bresp <= RESP_OKAY;
          regs_q[aw_idx_q] <= strb_merge(
            regs_q[aw_idx_q], w_data_q, w_strb_q);
          wr_pulse_o[aw_idx_q] <= 1'b1;
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Sampling regs_q here yields the pre-write value on a commit edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (ar_oor) begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end else begin
        rdata <= RO_MASK[ar_idx] ? hw_w[ar_idx] : regs_q[ar_idx];
        rresp <= RESP_OKAY;
      end
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed self-checking bench for axi4_lite_regfile.
// Inputs change on negedge; outputs are checked at negedge.
module tb_axi4_lite_regfile;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         awvalid, awready;
  logic [31:0]  awaddr;
  logic [2:0]   awprot;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [2:0]   arprot;
  logic         rvalid, rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [255:0] reg_o;
  logic [255:0] hw_i;
  logic [7:0]   wr_pulse_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  axi4_lite_regfile dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp),
    .reg_o(reg_o), .hw_i(hw_i),
    .wr_pulse_o(wr_pulse_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return reg_o[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // AW and W together in c0; returns at negedge of c2.
  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    awvalid = 1'b1; awaddr = a;
    wvalid  = 1'b1; wdata = d; wstrb = s;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
  endtask

  // AR in c0; returns at negedge of c1.
  task automatic rd(input logic [31:0] a);
    arvalid = 1'b1; araddr = a;
    step();
    arvalid = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    awvalid = 0; awaddr = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 0;
    bready = 1; arvalid = 0; araddr = 0;
    arprot = 0; rready = 1;
    hw_i = '0;
    hw_i[6*32 +: 32] = 32'hCAFEF00D;
    hw_i[7*32 +: 32] = 32'h0BADC0DE;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_regs", {31'b0, |reg_o}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_ni = 1'b1;
    step();
    chk("rdy_after_rst",
        {29'b0, awready, wready, arready}, 32'd7);

    // Same-cycle AW/W
    wr(32'h04, 32'hDEADBEEF, 4'hF);
    chk("t1_bvalid", {31'b0, bvalid}, 32'd1);
    chk("t1_bresp", {30'b0, bresp}, 32'd0);
    chk("t1_reg1", rg(1), 32'hDEADBEEF);
    chk("t1_pulse", {24'b0, wr_pulse_o}, 32'h02);
    step();
    chk("t1_bdone", {31'b0, bvalid}, 32'd0);
    chk("t1_pulse0", {24'b0, wr_pulse_o}, 32'h00);

    // W first, AW three cycles later
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'h5;
    step();
    wvalid = 0;
    for (int i = 1; i < 3; i++) begin
      chk("t2_wready", {31'b0, wready}, 32'd0);
      chk("t2_awready", {31'b0, awready}, 32'd1);
      step();
    end
    awvalid = 1; awaddr = 32'h08;
    step();
    awvalid = 0;
    chk("t2_c4_bvalid", {31'b0, bvalid}, 32'd0);
    step();
    chk("t2_c5_bvalid", {31'b0, bvalid}, 32'd1);
    chk("t2_reg2", rg(2), 32'h00220044);
    step();

    // RO and out-of-range writes
    wr(32'h1C, 32'hFFFFFFFF, 4'hF);
    chk("t3_ro_bresp", {30'b0, bresp}, 32'd2);
    chk("t3_ro_pulse", {24'b0, wr_pulse_o}, 32'h00);
    chk("t3_ro_reg7", rg(7), 32'd0);
    step();
    wr(32'h20, 32'hFFFFFFFF, 4'hF);
    chk("t3_oor_bresp", {30'b0, bresp}, 32'd2);
    chk("t3_oor_pulse", {24'b0, wr_pulse_o}, 32'h00);
    chk("t3_oor_reg0", rg(0), 32'd0);
    step();

    // Reads
    chk("t4_arready", {31'b0, arready}, 32'd1);
    rd(32'h18);
    chk("t4_rvalid", {31'b0, rvalid}, 32'd1);
    chk("t4_rdata", rdata, 32'hCAFEF00D);
    chk("t4_rresp", {30'b0, rresp}, 32'd0);
    step();
    chk("t4_rdone", {31'b0, rvalid}, 32'd0);
    rd(32'h40);
    chk("t4_oor_rdata", rdata, 32'd0);
    chk("t4_oor_rresp", {30'b0, rresp}, 32'd2);
    step();

    // Read sampled on the commit edge sees the old value
    awvalid = 1; awaddr = 32'h04;
    wvalid = 1; wdata = 32'h00005555; wstrb = 4'h3;
    step();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h04;
    step();
    arvalid = 0;
    chk("t5_old_rdata", rdata, 32'hDEADBEEF);
    chk("t5_reg1", rg(1), 32'hDEAD5555);
    step();

    // wstrb=0 commits OKAY, pulses, changes nothing
    wr(32'h04, 32'hFFFFFFFF, 4'h0);
    chk("t6_bresp", {30'b0, bresp}, 32'd0);
    chk("t6_pulse", {24'b0, wr_pulse_o}, 32'h02);
    chk("t6_reg1", rg(1), 32'hDEAD5555);
    step();

    // B backpressure with concurrent read
    bready = 0;
    wr(32'h0C, 32'h01020304, 4'hF);
    chk("t7_pulse", {24'b0, wr_pulse_o}, 32'h08);
    arvalid = 1; araddr = 32'h04;
    for (int i = 0; i < 5; i++) begin
      chk("t7_bvalid", {31'b0, bvalid}, 32'd1);
      chk("t7_bresp", {30'b0, bresp}, 32'd0);
      chk("t7_awready", {31'b0, awready}, 32'd0);
      chk("t7_wready", {31'b0, wready}, 32'd0);
      if (i == 1) begin
        chk("t7_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t7_rdata", rdata, 32'hDEAD5555);
        chk("t7_pulse0", {24'b0, wr_pulse_o}, 32'h00);
      end
      step();
      arvalid = 1'b0;
    end
    bready = 1;
    step();
    chk("t7_bdone", {31'b0, bvalid}, 32'd0);
    chk("t7_awready1", {31'b0, awready}, 32'd1);
    chk("t7_reg3", rg(3), 32'h01020304);

    // Reset with AW held: held flag must be discarded
    awvalid = 1; awaddr = 32'h14;
    step();
    awvalid = 0;
    chk("t8_awheld", {31'b0, awready}, 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("t8_awready", {31'b0, awready}, 32'd1);
    chk("t8_regs", {31'b0, |reg_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wvalid = 1; wdata = 32'h00000055; wstrb = 4'hF;
    step();
    wvalid = 0;
    step();
    step();
    chk("t8_no_b", {31'b0, bvalid}, 32'd0);
    awvalid = 1; awaddr = 32'h10;
    step();
    awvalid = 0;
    step();
    chk("t8_bvalid", {31'b0, bvalid}, 32'd1);
    chk("t8_reg4", rg(4), 32'h00000055);
    chk("t8_reg5", rg(5), 32'd0);
    step();

    // Reset with B and R responses pending
    bready = 0; rready = 0;
    wr(32'h0C, 32'h00000077, 4'hF);
    arvalid = 1; araddr = 32'h10;
    step();
    arvalid = 0;
    chk("t9_pre_b", {31'b0, bvalid}, 32'd1);
    chk("t9_pre_r", {31'b0, rvalid}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t9_bvalid", {31'b0, bvalid}, 32'd0);
    chk("t9_rvalid", {31'b0, rvalid}, 32'd0);
    chk("t9_rdata", rdata, 32'd0);
    chk("t9_reg3", rg(3), 32'd0);
    chk("t9_pulse", {24'b0, wr_pulse_o}, 32'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bready = 1; rready = 1;
    step();
    chk("t9_no_b", {31'b0, bvalid}, 32'd0);
    chk("t9_no_r", {31'b0, rvalid}, 32'd0);
    wr(32'h04, 32'h12345678, 4'hF);
    chk("t9_fresh_b", {31'b0, bvalid}, 32'd1);
    chk("t9_fresh_resp", {30'b0, bresp}, 32'd0);
    chk("t9_fresh_reg1", rg(1), 32'h12345678);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
